// File: rtl/alu_seq.sv
// Registered ALU: single-pass base integer ops, iterative RV32M mul/div.
// Define ALU_MULDIV_EN to compile in the multiply/divide datapath.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [4:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] base_res;
    logic [SH_W-1:0]  shamt;

    assign shamt = B_i[SH_W-1:0];

    always_comb begin
        base_res = '0;
        case (ALU_Operation_i[3:0])
            4'b0000: base_res = A_i + B_i;
            4'b0001: base_res = A_i - B_i;
            4'b0010: base_res = A_i ^ B_i;
            4'b0011: base_res = A_i | B_i;
            4'b0100: base_res = A_i & B_i;
            4'b0101: base_res = A_i << shamt;
            4'b0110: base_res = $signed(A_i) >>> shamt;
            4'b0111: base_res = A_i >> shamt;
            4'b1000: base_res = A_i | B_i;
            4'b1001: base_res = B_i << 12;
            4'b1010: base_res = A_i + B_i;
            4'b1011: base_res = {{(WIDTH-1){1'b0}}, $signed(A_i) < $signed(B_i)};
            4'b1100: base_res = A_i + B_i;
            4'b1101: base_res = A_i + B_i;
            4'b1110: base_res = {{(WIDTH-1){1'b0}}, A_i < B_i};
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // opd_q: multiplicand or divisor; acc_q: {hi, lo} product or {rem, quot}
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2:0]         f3_q, f3_d;
    logic               neg_q, neg_d;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_s, sub_s;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   dv, fix_res;

    assign sa    = A_i[WIDTH-1];
    assign sb    = B_i[WIDTH-1];
    assign mag_a = sa ? -A_i : A_i;
    assign mag_b = sb ? -B_i : B_i;
    assign add_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign sub_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
    assign prod  = neg_q ? -acc_q : acc_q;
    assign dv    = f3_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

    always_comb begin
        if (f3_q[2])
            fix_res = neg_q ? -dv : dv;
        else if (f3_q == 3'b000)
            fix_res = prod[WIDTH-1:0];
        else
            fix_res = prod[2*WIDTH-1:WIDTH];
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
`ifdef ALU_MULDIV_EN
        opd_d   = opd_q;
        acc_d   = acc_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (!ALU_Operation_i[4]) begin
                        state_d = S_DONE;
                        res_d   = base_res;
                    end else begin
`ifdef ALU_MULDIV_EN
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(WIDTH);
                        f3_d    = ALU_Operation_i[2:0];
                        // quotient keeps its sign only for a non-zero divisor
                        case (ALU_Operation_i[2:0])
                            3'b000: begin
                                opd_d = A_i;
                                acc_d = {{WIDTH{1'b0}}, B_i};
                                neg_d = 1'b0;
                            end
                            3'b001: begin
                                opd_d = mag_a;
                                acc_d = {{WIDTH{1'b0}}, mag_b};
                                neg_d = sa ^ sb;
                            end
                            3'b010: begin
                                opd_d = mag_a;
                                acc_d = {{WIDTH{1'b0}}, B_i};
                                neg_d = sa;
                            end
                            3'b011: begin
                                opd_d = A_i;
                                acc_d = {{WIDTH{1'b0}}, B_i};
                                neg_d = 1'b0;
                            end
                            3'b100: begin
                                opd_d = mag_b;
                                acc_d = {{WIDTH{1'b0}}, mag_a};
                                neg_d = (sa ^ sb) & (|B_i);
                            end
                            3'b110: begin
                                opd_d = mag_b;
                                acc_d = {{WIDTH{1'b0}}, mag_a};
                                neg_d = sa;
                            end
                            default: begin
                                opd_d = B_i;
                                acc_d = {{WIDTH{1'b0}}, A_i};
                                neg_d = 1'b0;
                            end
                        endcase
`else
                        state_d = S_DONE;
                        res_d   = '0;
`endif
                    end
                end
            end
            S_CALC: begin
`ifdef ALU_MULDIV_EN
                if (f3_q[2]) begin
                    if (!sub_s[WIDTH])
                        acc_d = {sub_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {add_s, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_FIX: begin
`ifdef ALU_MULDIV_EN
                state_d = S_DONE;
                res_d   = fix_res;
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE)
            zero_d = (res_d == '0);
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
            opd_q   <= '0;
            acc_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_MULDIV_EN
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign ALU_Result_o = res_q;
    assign Zero_o       = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: randomized ops against a reference model.
// Expectations follow the build (ALU_MULDIV_EN defined or not).
module tb_alu_seq;

`ifdef ALU_MULDIV_EN
    localparam int LAT_M   = 34;
    localparam int BUSY_M  = 33;
    localparam int RST_CYC = 4;
`else
    localparam int LAT_M   = 1;
    localparam int BUSY_M  = 0;
    localparam int RST_CYC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  opc;
    logic [31:0] A, B;
    logic        busy, done, zero;
    logic [31:0] res;

    logic        start16;
    logic [4:0]  opc16;
    logic [15:0] A16, B16;
    logic        busy16, done16, zero16;
    logic [15:0] res16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(rst_n), .start_i(start),
        .ALU_Operation_i(opc), .A_i(A), .B_i(B),
        .busy_o(busy), .done_o(done),
        .ALU_Result_o(res), .Zero_o(zero)
    );

    alu_seq #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clk(clk), .reset(rst_n), .start_i(start16),
        .ALU_Operation_i(opc16), .A_i(A16), .B_i(B16),
        .busy_o(busy16), .done_o(done16),
        .ALU_Result_o(res16), .Zero_o(zero16)
    );

    function automatic logic [31:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        int              sh = int'(b & 32'd31);
        bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (!op[4]) begin
            case (op[3:0])
                4'd0, 4'd10, 4'd12, 4'd13: return a + b;
                4'd1:  return a - b;
                4'd2:  return a ^ b;
                4'd3, 4'd8: return a | b;
                4'd4:  return a & b;
                4'd5:  return a << sh;
                4'd6:  return 32'(sa >>> sh);
                4'd7:  return a >> sh;
                4'd9:  return b << 12;
                4'd11: return (sa < sb) ? 32'd1 : 32'd0;
                4'd14: return (ua < ub) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
`ifdef ALU_MULDIV_EN
        case (op[2:0])
            3'd0: return 32'(sa * sb);
            3'd1: return 32'((sa * sb) >>> 32);
            3'd2: return 32'((sa * longint'(ub)) >>> 32);
            3'd3: return 32'((ua * ub) >> 32);
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
`else
        return 32'd0;
`endif
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt,
                          output logic [31:0] r, output logic z);
        lat = 0;
        bcnt = 0;
        r = '0;
        z = 1'b0;
        @(negedge clk);
        start = 1'b1; opc = op; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0; A = $urandom; B = $urandom; opc = 5'($urandom);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                r = res;
                z = zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, res, zero} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h zero=%b want 0 0 0 1",
                     busy, done, res, zero);
        end
    endtask

    task automatic test_base();
        logic [4:0]  op;
        logic [31:0] a, b, r, e;
        logic        z;
        int          lat, bc;
        logic [4:0]  dop [3] = '{5'd0, 5'd1, 5'd6};
        logic [31:0] da  [3] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000};
        logic [31:0] db  [3] = '{32'd1, 32'd5, 32'd33};
        logic [31:0] de  [3] = '{32'h8000_0000, 32'd0, 32'hC000_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(dop[i], da[i], db[i], lat, bc, r, z);
            checks++;
            if (r !== de[i] || z !== (de[i] == 0) || lat != 1) begin
                errors++;
                $display("FAIL base_directed%0d: got res=%h zero=%b lat=%0d want %h %b 1",
                         i, r, z, lat, de[i], de[i] == 0);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL base_pulse%0d: done=%b want 0", i, done);
            end
        end
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            e = ref_alu(op, a, b);
            run_op(op, a, b, lat, bc, r, z);
            checks++;
            if (r !== e || z !== (e == 0) || lat != 1 || bc != 0) begin
                errors++;
                $display("FAIL base_rand op=%0d a=%h b=%h: got res=%h zero=%b lat=%0d busy=%0d want %h %b 1 0",
                         op, a, b, r, z, lat, bc, e, e == 0);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [4:0]  op;
        logic [31:0] a, b, r, e;
        logic        z;
        int          lat, bc;
        logic [4:0]  dop [10] = '{5'd16, 5'd17, 5'd19, 5'd20, 5'd22,
                                  5'd21, 5'd22, 5'd20, 5'd22, 5'd27};
        logic [31:0] da  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                  32'h8000_0000, 32'h8000_0000, 32'd3};
        logic [31:0] db  [10] = '{32'd7, 32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};
        for (int i = 0; i < 10; i++) begin
            e = ref_alu(dop[i], da[i], db[i]);
            run_op(dop[i], da[i], db[i], lat, bc, r, z);
            checks++;
            if (r !== e || z !== (e == 0) || lat != LAT_M || bc != BUSY_M) begin
                errors++;
                $display("FAIL m_directed%0d: got res=%h zero=%b lat=%0d busy=%0d want %h %b %0d %0d",
                         i, r, z, lat, bc, e, e == 0, LAT_M, BUSY_M);
            end
        end
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(16, 31));
            a = $urandom;
            b = $urandom;
            if (i % 8 == 1) b = 0;
            if (i % 8 == 2) begin a = 32'h8000_0000; b = '1; end
            if (i % 8 == 3) b = $urandom_range(1, 9);
            e = ref_alu(op, a, b);
            run_op(op, a, b, lat, bc, r, z);
            checks++;
            if (r !== e || z !== (e == 0) || lat != LAT_M || bc != BUSY_M) begin
                errors++;
                $display("FAIL m_rand op=%0d a=%h b=%h: got res=%h zero=%b lat=%0d busy=%0d want %h %b %0d %0d",
                         op, a, b, r, z, lat, bc, e, e == 0, LAT_M, BUSY_M);
            end
        end
    endtask

    task automatic test_handshake();
        logic [31:0] a1, b1, e2;
        int          bad = 0;
        a1 = $urandom;
        b1 = $urandom;
        e2 = ref_alu(5'd21, 32'd100, 32'd3);
        @(negedge clk);
        start = 1'b1; opc = 5'd0; A = a1; B = b1;
        @(posedge clk);
        #1;
        opc = 5'd21; A = 32'd100; B = 32'd3;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || res !== a1 + b1) begin
            errors++;
            $display("FAIL hs_first: got done=%b res=%h want 1 %h", done, res, a1 + b1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hs_gap: got done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk);
        #1;
        opc = 5'd0; A = $urandom; B = $urandom;
        for (int k = 1; k <= LAT_M; k++) begin
            @(negedge clk);
            if (k < LAT_M && done !== 1'b0) bad++;
            A = $urandom;
            B = $urandom;
        end
        checks++;
        if (done !== 1'b1 || res !== e2 || bad != 0) begin
            errors++;
            $display("FAIL hs_second: got done=%b res=%h early=%0d want 1 %h 0",
                     done, res, bad, e2);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL hs_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int          bad = 0;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        start = 1'b1; opc = 5'd2; A = a; B = b;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done !== 1'(k % 2)) bad++;
            if (done && res !== (a ^ b)) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL back_to_back: %0d bad cycles, want 0", bad);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dcnt = 0;
        @(negedge clk);
        start = 1'b1; opc = 5'd16; A = 32'hFFFF_FFFD; B = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (RST_CYC) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, res, zero} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b res=%h zero=%b want 0 0 0 1",
                     busy, done, res, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d done pulses, want 0", dcnt);
        end
    endtask

    task automatic test_width16();
        int lat = 0;
        @(negedge clk);
        start16 = 1'b1; opc16 = 5'd0; A16 = 16'h7FFF; B16 = 16'd1;
        @(posedge clk);
        #1;
        start16 = 1'b0; A16 = 16'($urandom); B16 = 16'($urandom);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done16) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != 1 || res16 !== 16'h8000 || zero16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_add: got lat=%0d res=%h zero=%b want 1 8000 0",
                     lat, res16, zero16);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; opc = '0; A = '0; B = '0;
        start16 = 1'b0; opc16 = '0; A16 = '0; B16 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_base();
        test_muldiv();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_width16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
